// File: rtl/tty_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tty_uart_bridge                                                 |
// | Function : Shell character FIFO feeding an 8N1 UART transmitter.          |
// |            Define TTY_BRIDGE_CRLF_EN to expand LF into a CR,LF frame pair. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tty_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic [6:0] TTY_data,
    input  logic       TTY_en,
    input  logic       TTY_clear,
    output logic       TTY_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     c_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [6:0]      c_FF       = 7'h0C;
    localparam logic [7:0]      c_LF       = 8'h0A;
`ifdef TTY_BRIDGE_CRLF_EN
    localparam logic [7:0]      c_CR       = 8'h0D;
`endif

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [6:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_ready;
    logic [1:0]      r_state;
    logic [15:0]     r_clk_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_lf_pend;

    logic [1:0]      w_state_nx;
    logic [c_AW:0]   w_count_nx;
    logic [7:0]      w_load_byte;
    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic            w_lf_set;
    logic            w_lf_clr;
    logic            w_bit_end;
    logic            w_fifo_nempty;

    assign w_push        = TTY_en & r_ready & ~TTY_clear;
    assign w_fifo_nempty = (r_count != '0);
    assign w_bit_end     = (r_clk_cnt == c_BIT_LAST);

    // A clear suppresses the pop so the flushed head is never started.
    always_comb begin
        w_state_nx  = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_lf_set    = 1'b0;
        w_lf_clr    = 1'b0;
        w_load_byte = {1'b0, r_mem[r_rd_ptr]};
        case (r_state)
            c_ST_IDLE: begin
                if (w_fifo_nempty && !TTY_clear) begin
                    w_pop      = 1'b1;
                    w_load     = 1'b1;
                    w_state_nx = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_bit_end) w_state_nx = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_end && r_bit_cnt == 3'd7) w_state_nx = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_bit_end) begin
                    if (r_lf_pend) begin
                        w_load      = 1'b1;
                        w_load_byte = c_LF;
                        w_lf_clr    = 1'b1;
                        w_state_nx  = c_ST_START;
                    end else if (w_fifo_nempty && !TTY_clear) begin
                        w_pop      = 1'b1;
                        w_load     = 1'b1;
                        w_state_nx = c_ST_START;
                    end else begin
                        w_state_nx = c_ST_IDLE;
                    end
                end
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
`ifdef TTY_BRIDGE_CRLF_EN
        if (w_pop && w_load_byte == c_LF) begin
            w_load_byte = c_CR;
            w_lf_set    = 1'b1;
        end
`endif
    end

    always_comb begin
        w_count_nx = r_count;
        if (TTY_clear)           w_count_nx = c_CNT_ONE;
        else if (w_push && !w_pop) w_count_nx = r_count + c_CNT_ONE;
        else if (w_pop && !w_push) w_count_nx = r_count - c_CNT_ONE;
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge mclk) begin
        if (TTY_clear)   r_mem[0]        <= c_FF;
        else if (w_push) r_mem[r_wr_ptr] <= TTY_data;
    end

    // Clear leaves exactly one form feed queued at slot 0.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_count <= w_count_nx;
            r_ready <= (w_count_nx < c_DEPTH);
            if (TTY_clear) begin
                r_wr_ptr <= c_PTR_ONE;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_lf_pend <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift   <= w_load_byte;
                r_tx      <= 1'b0;
                r_clk_cnt <= '0;
                r_bit_cnt <= '0;
            end else if (r_state != c_ST_IDLE) begin
                if (!w_bit_end) begin
                    r_clk_cnt <= r_clk_cnt + 16'd1;
                end else begin
                    r_clk_cnt <= '0;
                    case (r_state)
                        c_ST_START: begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                        c_ST_DATA: begin
                            if (r_bit_cnt == 3'd7) begin
                                r_tx <= 1'b1;
                            end else begin
                                r_tx      <= r_shift[0];
                                r_shift   <= {1'b0, r_shift[7:1]};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                        default: r_tx <= 1'b1;
                    endcase
                end
            end
            if (w_lf_set)      r_lf_pend <= 1'b1;
            else if (w_lf_clr) r_lf_pend <= 1'b0;
        end
    end

    assign TTY_ready = r_ready;
    assign uart_tx   = r_tx;
    assign tx_busy   = (r_state != c_ST_IDLE) || w_fifo_nempty;

endmodule
`default_nettype wire

// File: tb/tb_tty_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tty_uart_bridge                                              |
// | Function : Self-checking bench for tty_uart_bridge (honours                |
// |            TTY_BRIDGE_CRLF_EN when defined).                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tty_uart_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef TTY_BRIDGE_CRLF_EN
    localparam int LF_BUSY = 1 + 20 * CPB;
`else
    localparam int LF_BUSY = 1 + 10 * CPB;
`endif

    logic       mclk      = 1'b0;
    logic       reset     = 1'b0;
    logic [6:0] TTY_data  = '0;
    logic       TTY_en    = 1'b0;
    logic       TTY_clear = 1'b0;
    logic       TTY_ready;
    logic       uart_tx;
    logic       tx_busy;

    int n_total = 0;
    int n_pass  = 0;

    tty_uart_bridge #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .mclk     (mclk),
        .reset    (reset),
        .TTY_data (TTY_data),
        .TTY_en   (TTY_en),
        .TTY_clear(TTY_clear),
        .TTY_ready(TTY_ready),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: FIFO as a queue, the line as a frame timeline indexed by cycle.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    logic [7:0] m_byte   = 8'hFF;
    int         m_t      = 0;
    bit         m_lf     = 1'b0;
    bit         m_ready  = 1'b0;

    task m_start(input logic [7:0] b);
        m_active = 1'b1;
        m_t      = 0;
        m_byte   = b;
`ifdef TTY_BRIDGE_CRLF_EN
        if (b == 8'h0A) begin
            m_byte = 8'h0D;
            m_lf   = 1'b1;
        end
`endif
    endtask

    always @(posedge mclk or posedge reset) begin
        bit acc;
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_lf     = 1'b0;
            m_ready  = 1'b0;
        end else begin
            acc = TTY_en && m_ready && !TTY_clear;
            if (m_active) begin
                m_t++;
                if (m_t == 10 * CPB) begin
                    m_active = 1'b0;
                    if (m_lf) begin
                        m_lf     = 1'b0;
                        m_active = 1'b1;
                        m_t      = 0;
                        m_byte   = 8'h0A;
                    end else if (m_q.size() != 0 && !TTY_clear) begin
                        m_start(m_q.pop_front());
                    end
                end
            end else if (m_q.size() != 0 && !TTY_clear) begin
                m_start(m_q.pop_front());
            end
            if (TTY_clear) begin
                m_q.delete();
                m_q.push_back(8'h0C);
            end else if (acc) begin
                m_q.push_back({1'b0, TTY_data});
            end
            m_ready = (m_q.size() < DEPTH);
        end
    end

    function automatic logic f_line();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    always @(negedge mclk) begin
        check("uart_tx", uart_tx, f_line());
        check("tx_busy", tx_busy, m_active || (m_q.size() != 0));
        check("TTY_ready", TTY_ready, m_ready);
    end

    // Independent line receiver collecting decoded frames.
    logic [7:0] rx_q[$];
    logic [9:0] rx_f[$];
    logic       rx_on = 1'b0;
    int         rx_t  = 0;
    logic [9:0] rx_bits = '0;

    always @(negedge mclk or posedge reset) begin
        if (reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2) begin
                rx_bits[rx_t / CPB] = uart_tx;
                if (rx_t / CPB == 9) begin
                    rx_q.push_back(rx_bits[8:1]);
                    rx_f.push_back(rx_bits);
                    rx_on = 1'b0;
                end
            end
        end
    end

    task automatic write(input logic [6:0] d);
        TTY_en   = 1'b1;
        TTY_data = d;
        @(posedge mclk); #1;
        TTY_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 3000) begin
            @(posedge mclk); #1;
            n++;
        end
        check("idle_timeout", (n < 3000), 1);
        repeat (2) @(posedge mclk);
        #1;
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check(name, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, exp[i]);
        rx_q.delete();
        rx_f.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp[$];
        int n;
        int acc;

        #1 reset = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_ready", TTY_ready, 0);
        check("rst_busy", tx_busy, 0);
        reset = 1'b0;
        @(posedge mclk); #1;
        check("ready_after_rst", TTY_ready, 1);

        // Single 'A' frame: bit pattern and busy duration.
        write(7'h41);
        n = 0;
        while (tx_busy && n < 200) begin
            @(posedge mclk); #1;
            n++;
        end
        check("busy_cycles_41", n, 41);
        check("frame_bits_41", (rx_f.size() > 0) ? {22'h0, rx_f[0]} : 32'hDEAD, 10'b1010000010);
        exp = '{8'h41};
        check_rx("rx_41", exp);
        wait_idle();

        // Hold write strobe while line busy: FIFO fills, surplus dropped.
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            TTY_en   = 1'b1;
            TTY_data = 7'(8'h30 + i);
            if (TTY_ready) acc++;
            @(posedge mclk); #1;
        end
        TTY_en = 1'b0;
        check("accepts", acc, 9);
        check("ready_full", TTY_ready, 0);
        wait_idle();
        exp.delete();
        for (int i = 0; i < 9; i++) exp.push_back(8'(8'h30 + i));
        check_rx("rx_fill", exp);

        // Clear during a frame: current frame finishes, queue replaced by FF.
        write(7'h48);
        write(7'h49);
        repeat (8) @(posedge mclk);
        #1;
        TTY_clear = 1'b1;
        @(posedge mclk); #1;
        TTY_clear = 1'b0;
        wait_idle();
        exp = '{8'h48, 8'h0C};
        check_rx("rx_clear", exp);

        // Write and clear together: write dropped.
        TTY_en    = 1'b1;
        TTY_data  = 7'h5A;
        TTY_clear = 1'b1;
        @(posedge mclk); #1;
        TTY_en    = 1'b0;
        TTY_clear = 1'b0;
        wait_idle();
        exp = '{8'h0C};
        check_rx("rx_en_clear", exp);

        // Line feed handling.
        write(7'h0A);
        n = 0;
        while (tx_busy && n < 300) begin
            @(posedge mclk); #1;
            n++;
        end
        check("busy_cycles_lf", n, LF_BUSY);
        wait_idle();
`ifdef TTY_BRIDGE_CRLF_EN
        exp = '{8'h0D, 8'h0A};
`else
        exp = '{8'h0A};
`endif
        check_rx("rx_lf", exp);

        // Random traffic against the reference model.
        for (int i = 0; i < 700; i++) begin
            TTY_en    = ($urandom_range(0, 99) < 35);
            TTY_data  = ($urandom_range(0, 9) == 0) ? 7'h0A : 7'($urandom_range(0, 127));
            TTY_clear = ($urandom_range(0, 149) == 0);
            @(posedge mclk); #1;
        end
        TTY_en    = 1'b0;
        TTY_clear = 1'b0;
        wait_idle();
        rx_q.delete();
        rx_f.delete();

        // Asynchronous reset in the middle of data bit 3.
        write(7'h55);
        repeat (17) @(posedge mclk);
        #3 reset = 1'b1;
        #1;
        check("midframe_rst_tx", uart_tx, 1);
        check("midframe_rst_busy", tx_busy, 0);
        @(posedge mclk); #1;
        reset = 1'b0;
        repeat (60) @(posedge mclk);
        #1;
        check("post_rst_busy", tx_busy, 0);
        exp.delete();
        check_rx("rx_after_rst", exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
